// File: rtl/dmem_block_mover.sv
// Data-memory block mover: copies or fills a run of bytes through the MEM-stage port.
// Latency: copy takes 3 cycles per byte, fill 1 cycle per byte, plus a 1-cycle DONE state.
// No backpressure: memory accepts one access per cycle; the pipeline stalls on busy.
module dmem_block_mover #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              mode,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [ADDR_W-1:0] len,
   input  logic [DATA_W-1:0] fill_val,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   // RD issues the read, CAP waits out the one-cycle read latency, WR stores it.
   // FW writes the fill byte every cycle. DONE is a one-cycle completion marker.
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD   = 3'd1,
      S_CAP  = 3'd2,
      S_WR   = 3'd3,
      S_FW   = 3'd4,
      S_DONE = 3'd5
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] src_q, src_d;
   logic [ADDR_W-1:0] dst_q, dst_d;
   logic [ADDR_W-1:0] rem_q, rem_d;
   logic [DATA_W-1:0] fill_q, fill_d;
   logic [DATA_W-1:0] buf_q, buf_d;
   logic              last_byte;

   // The byte being written now is the final one of the block.
   assign last_byte = (rem_q == ADDR_W'(1));

   // State register; reset returns to IDLE immediately, which drops all strobes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode: start is only looked at in IDLE, abort only while busy.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (len == '0) begin
                  state_d = S_DONE;
               end else if (mode) begin
                  state_d = S_FW;
               end else begin
                  state_d = S_RD;
               end
            end
         end
         S_RD:    state_d = abort ? S_DONE : S_CAP;
         S_CAP:   state_d = abort ? S_DONE : S_WR;
         S_WR:    state_d = (abort || last_byte) ? S_DONE : S_RD;
         S_FW:    state_d = (abort || last_byte) ? S_DONE : S_FW;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath next-state: latch the command, capture read data, step the pointers.
   always_comb begin
      src_d  = src_q;
      dst_d  = dst_q;
      rem_d  = rem_q;
      fill_d = fill_q;
      buf_d  = buf_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               src_d  = src_addr;
               dst_d  = dst_addr;
               rem_d  = len;
               fill_d = fill_val;
            end
         end
         S_CAP: begin
            buf_d = mem_rdata;
         end
         S_WR: begin
            // Pointers wrap naturally at the top of the address space.
            src_d = src_q + ADDR_W'(1);
            dst_d = dst_q + ADDR_W'(1);
            rem_d = rem_q - ADDR_W'(1);
         end
         S_FW: begin
            dst_d = dst_q + ADDR_W'(1);
            rem_d = rem_q - ADDR_W'(1);
         end
         default: begin
         end
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         src_q  <= '0;
         dst_q  <= '0;
         rem_q  <= '0;
         fill_q <= '0;
         buf_q  <= '0;
      end else begin
         src_q  <= src_d;
         dst_q  <= dst_d;
         rem_q  <= rem_d;
         fill_q <= fill_d;
         buf_q  <= buf_d;
      end
   end

   // Moore output decode: strobes depend only on state and registers, never on mem_rdata.
   always_comb begin
      busy      = 1'b0;
      done      = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (state_q)
         S_RD: begin
            busy     = 1'b1;
            mem_read = 1'b1;
            mem_addr = src_q;
         end
         S_CAP: begin
            busy = 1'b1;
         end
         S_WR: begin
            busy      = 1'b1;
            mem_write = 1'b1;
            mem_addr  = dst_q;
            mem_wdata = buf_q;
         end
         S_FW: begin
            busy      = 1'b1;
            mem_write = 1'b1;
            mem_addr  = dst_q;
            mem_wdata = fill_q;
         end
         S_DONE: begin
            done = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_dmem_block_mover.sv
// Testbench for dmem_block_mover: byte-array memory model plus a sequential reference.
// Expected writes come from plain per-byte copy/fill semantics applied to a model array.
// Each command is checked for timing, strobe addresses/data, busy/done and final memory image.
module tb_dmem_block_mover;

   logic       clk;
   logic       reset;
   logic       start;
   logic       mode;
   logic [7:0] src_addr;
   logic [7:0] dst_addr;
   logic [7:0] len;
   logic [7:0] fill_val;
   logic       abort;
   logic       busy;
   logic       done;
   logic       mem_read;
   logic       mem_write;
   logic [7:0] mem_addr;
   logic [7:0] mem_wdata;
   logic [7:0] mem_rdata;

   logic [7:0] ram    [0:255];
   logic [7:0] refmem [0:255];
   logic       load_ram;

   int checks = 0;
   int errors = 0;

   dmem_block_mover #(.ADDR_W(8), .DATA_W(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .mode      (mode),
      .src_addr  (src_addr),
      .dst_addr  (dst_addr),
      .len       (len),
      .fill_val  (fill_val),
      .abort     (abort),
      .busy      (busy),
      .done      (done),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory with one-cycle read latency; load_ram copies the model image in.
   always @(posedge clk) begin
      if (load_ram) begin
         for (int i = 0; i < 256; i++) ram[i] <= refmem[i];
      end else begin
         if (mem_write) ram[mem_addr] <= mem_wdata;
         if (mem_read) mem_rdata <= ram[mem_addr];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic load_image();
      @(negedge clk);
      load_ram = 1'b1;
      @(negedge clk);
      load_ram = 1'b0;
   endtask

   task automatic check_ram(input string tag);
      int mism = 0;
      for (int i = 0; i < 256; i++) if (ram[i] !== refmem[i]) mism++;
      chk(tag, mism, 0);
   endtask

   // Run one command; abort_at = n asserts abort during the n-th write (0 = never);
   // poke pulses a conflicting start while the command is busy.
   task automatic run_cmd(input bit m, input logic [7:0] s, input logic [7:0] d,
                          input logic [7:0] l, input logic [7:0] f,
                          input int abort_at, input bit poke);
      int cyc;
      int nwr;
      int nrd;
      int lat;
      int nbytes;
      int exp_lat;
      bit both;
      logic [7:0] ea;
      logic [7:0] ed;
      @(negedge clk);
      mode = m; src_addr = s; dst_addr = d; len = l; fill_val = f; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 1; nwr = 0; nrd = 0; lat = 0; both = 1'b0;
      while (cyc <= 1000 && lat == 0) begin
         abort = 1'b0;
         start = 1'b0;
         if (mem_read && mem_write) both = 1'b1;
         if (done) begin
            lat = cyc;
         end else begin
            chk("busy_during_cmd", busy, 1);
            if (mem_read) begin
               ea = s + 8'(nrd);
               chk("read_addr", mem_addr, ea);
               nrd++;
            end
            if (mem_write) begin
               ea = d + 8'(nwr);
               ed = m ? f : refmem[s + 8'(nwr)];
               chk("write_addr", mem_addr, ea);
               chk("write_data", mem_wdata, ed);
               refmem[ea] = ed;
               nwr++;
               if (nwr == abort_at) abort = 1'b1;
            end
            if (poke && cyc == 2) begin
               start = 1'b1; mode = ~m; src_addr = ~s; dst_addr = ~d;
               len = 8'd1; fill_val = ~f;
            end
         end
         if (lat == 0) begin
            @(negedge clk);
            cyc++;
         end
      end
      nbytes  = (abort_at > 0 && abort_at < int'(l)) ? abort_at : int'(l);
      exp_lat = m ? nbytes + 1 : 3 * nbytes + 1;
      chk("done_latency", lat, exp_lat);
      chk("write_count", nwr, nbytes);
      chk("read_count", nrd, m ? 0 : nbytes);
      chk("read_write_overlap", both, 0);
      chk("busy_at_done", busy, 0);
      @(negedge clk);
      abort = 1'b0;
      chk("done_single_pulse", done, 0);
      chk("idle_strobes", {mem_read, mem_write, busy}, 0);
      check_ram("ram_image");
   endtask

   initial begin
      logic [7:0] rs;
      logic [7:0] rd;
      logic [7:0] rl;
      logic [7:0] rf;
      int         ra;
      reset = 1'b1; start = 1'b0; mode = 1'b0; src_addr = '0; dst_addr = '0;
      len = '0; fill_val = '0; abort = 1'b0; load_ram = 1'b0;
      for (int i = 0; i < 256; i++) refmem[i] = 8'($urandom);
      #1;
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_strobes", {mem_read, mem_write}, 0);
      chk("reset_addr", mem_addr, 0);
      chk("reset_wdata", mem_wdata, 0);
      load_image();
      @(negedge clk);
      reset = 1'b0;
      check_ram("initial_image");

      // Fill 4 bytes at 0x10 with 0xA5.
      run_cmd(1'b1, 8'h00, 8'h10, 8'd4, 8'hA5, 0, 1'b0);

      // Copy 3 preloaded bytes from 0x20 to 0x40.
      refmem[8'h20] = 8'h11; refmem[8'h21] = 8'h22; refmem[8'h22] = 8'h33;
      load_image();
      run_cmd(1'b0, 8'h20, 8'h40, 8'd3, 8'h00, 0, 1'b0);
      chk("copy_byte0", ram[8'h40], 8'h11);
      chk("copy_byte2", ram[8'h42], 8'h33);

      // Fill wrapping past the top of memory.
      run_cmd(1'b1, 8'h00, 8'hFE, 8'd3, 8'h5C, 0, 1'b0);
      chk("wrap_low_byte", ram[8'h00], 8'h5C);

      // Zero length, then a copy with a stray start while busy.
      run_cmd(1'b0, 8'h30, 8'h50, 8'd0, 8'h00, 0, 1'b0);
      run_cmd(1'b0, 8'h30, 8'h50, 8'd5, 8'h00, 0, 1'b1);

      // Abort during the second write of an 8-byte copy.
      run_cmd(1'b0, 8'h70, 8'h90, 8'd8, 8'h00, 2, 1'b0);

      // Overlapping forward copy: source bytes get overwritten as it goes.
      run_cmd(1'b0, 8'h60, 8'h62, 8'd6, 8'h00, 0, 1'b0);

      // Reset in the middle of a fill: two bytes land, the third is cut off.
      @(negedge clk);
      mode = 1'b1; dst_addr = 8'h80; len = 8'd10; fill_val = 8'h3C; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("midreset_write", mem_write, 0);
      chk("midreset_busy", busy, 0);
      chk("midreset_done", done, 0);
      refmem[8'h80] = 8'h3C;
      refmem[8'h81] = 8'h3C;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("postreset_idle", {busy, done, mem_read, mem_write}, 0);
      check_ram("midreset_image");
      run_cmd(1'b1, 8'h00, 8'hC0, 8'd2, 8'h77, 0, 1'b0);

      // Randomized commands, some aborted, some with stray starts.
      for (int t = 0; t < 14; t++) begin
         rs = 8'($urandom);
         rd = 8'($urandom);
         rl = 8'($urandom_range(1, 24));
         rf = 8'($urandom);
         ra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, int'(rl))) : 0;
         run_cmd(1'($urandom_range(0, 1)), rs, rd, rl, rf, ra, 1'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
